// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers.
//
// Sits beside the execute-stage ALU. One operation is accepted per start
// pulse while idle. The result is computed at the accept edge and parked in
// an internal holding register. It is copied into HI/LO after a fixed busy
// window of MUL_CYCLES or DIV_CYCLES cycles.
//
// Parameters
//   WIDTH       operand / HI / LO width
//   MUL_CYCLES  busy cycles for MULT/MULTU/MADD*/MSUB* (>=1)
//   DIV_CYCLES  busy cycles for DIV/DIVU (>=1)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-low reset
//   start  in   issue op this cycle
//   req    in   exception/interrupt flush; suppresses start
//   op     in   0 NONE 1 MULT 2 MULTU 3 DIV 4 DIVU 5 MTHI 6 MTLO
//               7 MADD 8 MADDU 9 MSUB 10 MSUBU (11-15 reserved)
//   A, B   in   operands rs / rt
//   busy   out  operation in flight (registered)
//   hi, lo out  HI / LO registers
//   dz     out  one-cycle divide-by-zero pulse
//
// Build option
//   MDU_MADD_EN  when defined, ops 7-10 (multiply-accumulate) are built;
//                otherwise they are treated as reserved.
module mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             req,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t              r_state, w_state_n;
  logic [CW-1:0]       r_cnt, w_cnt_n;
  logic                r_busy, w_busy_n;
  logic                w_commit;

  logic [WIDTH-1:0]    r_hi, r_lo;
  logic [WIDTH-1:0]    r_res_hi, r_res_lo;
  logic                r_dz;

  // ---------------- op decode ----------------
  logic w_op_ok, w_is_mul, w_is_div, w_signed;
`ifdef MDU_MADD_EN
  logic w_is_macc, w_is_sub;
`endif

  always_comb begin
    w_op_ok  = 1'b0;
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_signed = 1'b0;
`ifdef MDU_MADD_EN
    w_is_macc = 1'b0;
    w_is_sub  = 1'b0;
`endif
    case (op)
      OP_MULT:  begin w_op_ok = 1'b1; w_is_mul = 1'b1; w_signed = 1'b1; end
      OP_MULTU: begin w_op_ok = 1'b1; w_is_mul = 1'b1; end
      OP_DIV:   begin w_op_ok = 1'b1; w_is_div = 1'b1; w_signed = 1'b1; end
      OP_DIVU:  begin w_op_ok = 1'b1; w_is_div = 1'b1; end
      OP_MTHI:  w_op_ok = 1'b1;
      OP_MTLO:  w_op_ok = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin w_op_ok = 1'b1; w_is_mul = 1'b1; w_is_macc = 1'b1; w_signed = 1'b1; end
      OP_MADDU: begin w_op_ok = 1'b1; w_is_mul = 1'b1; w_is_macc = 1'b1; end
      OP_MSUB:  begin w_op_ok = 1'b1; w_is_mul = 1'b1; w_is_macc = 1'b1; w_is_sub = 1'b1;
                      w_signed = 1'b1; end
      OP_MSUBU: begin w_op_ok = 1'b1; w_is_mul = 1'b1; w_is_macc = 1'b1; w_is_sub = 1'b1; end
`else
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_op_ok = 1'b0;
`endif
      default:  w_op_ok = 1'b0;
    endcase
  end

  // req wins over start; nothing is accepted while an op is in flight
  logic w_acc, w_div0;
  assign w_acc  = start & ~req & ~r_busy & w_op_ok;
  assign w_div0 = w_is_div & (B == '0);

  // ---------------- multiply ----------------
  // Sign-extend to 2W and keep the low 2W bits: equals the signed product
  // modulo 2^(2W), so one multiplier serves both flavours.
  logic [2*WIDTH-1:0] w_ax, w_bx, w_prod, w_mul_res;
  assign w_ax   = {{WIDTH{w_signed & A[WIDTH-1]}}, A};
  assign w_bx   = {{WIDTH{w_signed & B[WIDTH-1]}}, B};
  assign w_prod = w_ax * w_bx;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] w_macc;
  assign w_macc    = w_is_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
  assign w_mul_res = w_is_macc ? w_macc : w_prod;
`else
  assign w_mul_res = w_prod;
`endif

  // ---------------- divide ----------------
  // Magnitude divide then re-sign. MIN/-1 falls out naturally: |MIN| = 2^(W-1)
  // divided by 1, both signs negative, so the quotient stays MIN, remainder 0.
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_q, w_r;
  assign w_a_neg  = w_signed & A[WIDTH-1];
  assign w_b_neg  = w_signed & B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -A : A;
  assign w_b_mag  = w_b_neg ? -B : B;
  // divisor of zero never commits; substitute 1 to keep the divider defined
  assign w_b_safe = (w_b_mag == '0) ? WIDTH'(1) : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_q      = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_r      = w_a_neg ? -w_r_mag : w_r_mag;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_busy  <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_busy_n  = r_busy;
    w_commit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc && w_is_mul) begin
          w_state_n = S_MUL;
          w_cnt_n   = MUL_LD;
          w_busy_n  = 1'b1;
        end else if (w_acc && w_is_div && !w_div0) begin
          w_state_n = S_DIV;
          w_cnt_n   = DIV_LD;
          w_busy_n  = 1'b1;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == '0) begin
          w_commit  = 1'b1;
          w_state_n = S_IDLE;
          w_busy_n  = 1'b0;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  // ---------------- HI/LO datapath ----------------
  // accept and commit are mutually exclusive (accept needs busy low)
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_dz     <= 1'b0;
    end else begin
      r_dz <= w_acc & w_div0;
      if (w_acc) begin
        if (op == OP_MTHI) r_hi <= A;
        if (op == OP_MTLO) r_lo <= A;
        if (w_is_mul) {r_res_hi, r_res_lo} <= w_mul_res;
        if (w_is_div && !w_div0) begin
          r_res_hi <= w_r;
          r_res_lo <= w_q;
        end
      end
      if (w_commit) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign dz   = r_dz;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: the driver issues ops and pushes the expected
// event (commit or divide-by-zero pulse, with its cycle and HI/LO values) into
// a queue; a monitor pops and compares when the DUT shows the event.
module tb_mdu_unit;
  localparam int W = 32;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, req;
  logic [3:0] op;
  logic [W-1:0] A, B;
  logic busy, dz;
  logic [W-1:0] hi, lo;

  mdu_unit #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .req(req), .op(op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_dz;
    int           t;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference state
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int m_end = -1;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // behavioural model: decides acceptance and the resulting event
  task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic r);
    bit valid, acc;
    logic [63:0] p, res;
    int sa, sb, sq, sr;
    exp_t e;
    valid = (o >= 4'd1 && o <= 4'd6) || (MADD_EN && o >= 4'd7 && o <= 4'd10);
    acc = reset && s && !r && (cyc > m_end) && valid;
    if (!acc) return;
    if (o == 4'd1 || o == 4'd7 || o == 4'd9) p = 64'(longint'(int'(a)) * longint'(int'(b)));
    else p = {32'b0, a} * {32'b0, b};
    case (o)
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      4'd1, 4'd2, 4'd7, 4'd8, 4'd9, 4'd10: begin
        if (o == 4'd7 || o == 4'd8) res = {m_hi, m_lo} + p;
        else if (o == 4'd9 || o == 4'd10) res = {m_hi, m_lo} - p;
        else res = p;
        {m_hi, m_lo} = res;
        e = '{1'b0, cyc + 1 + MC, m_hi, m_lo};
        q.push_back(e);
        m_end = cyc + MC;
      end
      4'd3, 4'd4: begin
        if (b == '0) begin
          e = '{1'b1, cyc + 1, m_hi, m_lo};
          q.push_back(e);
        end else begin
          if (o == 4'd4) begin
            m_lo = a / b;
            m_hi = a % b;
          end else begin
            sa = int'(a); sb = int'(b);
            if (sa == 32'sh80000000 && sb == -1) begin sq = sa; sr = 0; end
            else begin sq = sa / sb; sr = sa % sb; end
            m_lo = sq; m_hi = sr;
          end
          e = '{1'b0, cyc + 1 + DC, m_hi, m_lo};
          q.push_back(e);
          m_end = cyc + DC;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic r);
    @(negedge clk);
    op = o; A = a; B = b; start = s; req = r;
    model(o, a, b, s, r);
  endtask

  task automatic idle();
    step(4'd0, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc <= m_end + 1 && n < 40) begin idle(); n++; end
    checks++;
    if (cyc <= m_end + 1) begin
      errors++;
      $display("FAIL wait_idle timeout cyc %0d expected end %0d", cyc, m_end);
    end
    idle(); idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; start = 1'b0; req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    q.delete();
    m_hi = '0; m_lo = '0; m_end = -1;
    chk("rst_busy", {31'b0, busy}, '0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_dz", {31'b0, dz}, '0);
    reset = 1'b1;
  endtask

  // monitor
  initial begin
    bit pb = 1'b0;
    logic [W-1:0] h0 = '0, l0 = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        pb = 1'b0;
      end else begin
        if (dz) begin
          checks++;
          if (q.size() == 0 || !q[0].is_dz) begin
            errors++;
            $display("FAIL dz_unexpected got dz=1 expected no pulse (cyc %0d)", cyc);
          end else begin
            e = q.pop_front();
            chk("dz_cycle", W'(cyc), W'(e.t));
            chk("dz_hi", hi, e.hi);
            chk("dz_lo", lo, e.lo);
            chk("dz_busy", {31'b0, busy}, '0);
          end
        end
        if (busy && !pb) begin
          checks++;
          if (q.size() == 0 || q[0].is_dz) begin
            errors++;
            $display("FAIL busy_unexpected got busy=1 expected 0 (cyc %0d)", cyc);
          end
          h0 = hi; l0 = lo;
        end else if (busy && pb) begin
          chk("hold_hi", hi, h0);
          chk("hold_lo", lo, l0);
        end
        if (!busy && pb) begin
          checks++;
          if (q.size() == 0 || q[0].is_dz) begin
            errors++;
            $display("FAIL commit_unexpected got busy fall expected none (cyc %0d)", cyc);
          end else begin
            e = q.pop_front();
            chk("commit_cycle", W'(cyc), W'(e.t));
            chk("commit_hi", hi, e.hi);
            chk("commit_lo", lo, e.lo);
          end
        end
        pb = busy;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] o;
    logic [W-1:0] a, b;
    reset = 1'b0; start = 1'b0; req = 1'b0; op = '0; A = '0; B = '0;
    do_reset();

    // multiply signed vs unsigned
    step(4'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0); wait_idle();
    step(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0); wait_idle();
    // divides
    step(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0); wait_idle();
    step(4'd4, 32'd7, 32'd2, 1'b1, 1'b0); wait_idle();
    step(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0); wait_idle();
    // divide by zero with known HI/LO
    step(4'd5, 32'h11, 32'd0, 1'b1, 1'b0);
    step(4'd6, 32'h22, 32'd0, 1'b1, 1'b0);
    step(4'd3, 32'd5, 32'd0, 1'b1, 1'b0); wait_idle();
    // flushed start, then probe HI/LO with a divide by zero
    step(4'd1, 32'd9, 32'd9, 1'b1, 1'b1); idle(); idle();
    step(4'd4, 32'd1, 32'd0, 1'b1, 1'b0); wait_idle();
    // starts while busy are ignored
    step(4'd2, 32'd3, 32'd4, 1'b1, 1'b0);
    step(4'd4, 32'd9, 32'd2, 1'b1, 1'b0);
    step(4'd5, 32'hDEAD, 32'd0, 1'b1, 1'b0);
    step(4'd1, 32'd7, 32'd7, 1'b1, 1'b0); wait_idle();
    // MTHI/MTLO then MADD; without the option the probe shows HI/LO untouched
    step(4'd5, 32'h0, 32'd0, 1'b1, 1'b0);
    step(4'd6, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
    step(4'd7, 32'd1, 32'd1, 1'b1, 1'b0); wait_idle();
    step(4'd3, 32'd1, 32'd0, 1'b1, 1'b0); wait_idle();

    // randomized traffic, one potential issue every cycle
    for (int i = 0; i < 600; i++) begin
      o = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      step(o, a, b, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end
    wait_idle();

    // reset during a divide
    step(4'd3, 32'd100, 32'd3, 1'b1, 1'b0);
    idle(); idle(); idle();
    do_reset();
    idle(); idle();
    step(4'd4, 32'd100, 32'd7, 1'b1, 1'b0); wait_idle();

    chk("drain_queue", W'(q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
# mdu_unit

Parametrised multi-cycle multiply/divide unit that extends the single-cycle E-stage ALU with HI/LO register arithmetic. It accepts one operation per start pulse, computes signed or unsigned multiply/divide over a fixed, configurable latency, and holds results in internal HI/LO registers that the datapath reads combinationally. It sits beside the ALU in the execute stage. Hazard logic stalls the pipeline on `busy` (or `start` with an MDU op). The exception/interrupt logic cancels a start through `req`.

## Interface
- `WIDTH`, default 32: operand and HI/LO width.
- `MUL_CYCLES`, default 5: busy cycles for multiply-class operations (≥1).
- `DIV_CYCLES`, default 10: busy cycles for divide operations (≥1).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low; reset taken at a rising edge with `reset`=0.
- `start`  in  1  issue operation `op` this cycle.
- `req`  in  1  exception/interrupt flush; when 1, `start` is ignored.
- `op`  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11–15 reserved.
- `A`  in  WIDTH  operand rs.
- `B`  in  WIDTH  operand rt.
- `busy`  out  1  operation in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `dz`  out  1  one-cycle divide-by-zero pulse.

## Operation
- **Accept condition.** An operation is accepted at an edge where `reset`=1, `start`=1, `req`=0, `busy`=0 and `op` is 1–10. Op 0, reserved ops, and any start while `busy`=1 are ignored; the controller must stall the issuing instruction.
- **Operand capture.** `A` and `B` are latched at the accept edge. Later input changes have no effect.
- **MTHI / MTLO.** `hi` or `lo` is set to `A` at the accept edge. No busy phase.
- **MULT / MULTU.** The 2·WIDTH product (signed or unsigned) is formed into {HI,LO}.
- **MADD / MADDU / MSUB / MSUBU.** {HI,LO} ± product, computed modulo 2^(2·WIDTH). HI/LO values are sampled at the accept edge.
- **DIV / DIVU.**
  - LO = quotient, truncated toward zero.
  - HI = remainder, taking the sign of the dividend (`A`).
  - Signed MIN/−1 gives LO = MIN and HI = 0.
- **Divide by zero** (`B`=0 on DIV/DIVU): HI/LO unchanged, no busy phase, `dz`=1 for the single cycle after the accept edge.
- **State machine.**
  - States: IDLE, MUL, DIV.
  - IDLE → MUL on an accepted op 1, 2, or 7–10. IDLE → DIV on an accepted op 3 or 4 with `B`≠0.
  - On entry, a down-counter is loaded with MUL_CYCLES−1 or DIV_CYCLES−1.
  - Counter = 0 in MUL/DIV → commit the result to HI/LO and return to IDLE. Otherwise the counter decrements.
- **Result holding.** The result is held in an internal register from the accept edge. `hi`/`lo` show old values until commit.
- **`req` while busy.** Asserting `req` while busy does not abort; the in-flight instruction is already past E.

## Timing
- **Reset values.** `busy`=0, `hi`=0, `lo`=0, `dz`=0, state IDLE, counter 0.
- **Reset mid-operation** aborts with no commit; HI/LO are cleared to 0.
- **`busy`** is registered. It is high from the cycle after the accept edge for exactly MUL_CYCLES or DIV_CYCLES cycles.
- **Commit edge.** HI/LO update at the edge that ends the last busy cycle. `busy` falls and the new `hi`/`lo` become visible in the same cycle.
- **Back-to-back.** A new start is accepted at that same commit edge only if `busy` was sampled 0. Back-to-back ops therefore have a one-cycle minimum gap after the busy window.
- **MTHI/MTLO** values are visible in the cycle after the accept edge.
- **Simultaneous `start` and `req`.** `req` wins: no state change, no `dz`.

## Configuration
- `MDU_MADD_EN`:
  - Defined: ops 7–10 are implemented as described.
  - Undefined: ops 7–10 are treated as reserved (ignored, no busy, HI/LO unchanged), and the accumulate adder is not built.

## Test plan
- **Reset.** Hold `reset`=0 for 2 cycles, including mid-DIV → `busy`=0, `hi`=`lo`=0, `dz`=0.
- **MULT vs MULTU.**
  - MULT A=0xFFFFFFFF, B=2 → `busy` high 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
  - MULTU with the same operands → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- **Signed divide.**
  - DIV A=0xFFFFFFF9 (−7), B=2 → `busy` 10 cycles, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU A=7, B=2 → `lo`=3, `hi`=1.
- **Divide by zero.** DIV with B=0, prior hi/lo=0x11/0x22 → `dz` pulses 1 cycle, `busy` stays 0, hi/lo unchanged.
- **Flush and ignored starts.**
  - `start`=1 with `req`=1 on MULT → no busy, HI/LO unchanged.
  - Start issued while busy → ignored; the first result still commits at its correct cycle.
- **MTHI/MTLO and MADD** (with `MDU_MADD_EN`).
  - MTHI 0 and MTLO 0xFFFFFFFF, then MADD A=1, B=1 → `hi`=1, `lo`=0.
  - With the macro undefined, the same MADD → no busy, hi/lo unchanged.
